// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: shared FSM encoding and default data width for the DLX memory slave
package dlx_mem_pkg;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;
endpackage

// File: rtl/dlx_sram.sv
// dlx_sram: synchronous single-port read-first array with registered read data
module dlx_sram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= din_i;
        dout_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/dlx_mem_slave.sv
// dlx_mem_slave: wait-state memory responder for the DLX REQ/MR/MW/busy handshake with a host load port
module dlx_mem_slave
    import dlx_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              REQ,
    input  logic              MR,
    input  logic              MW,
    input  logic [31:0]       AD,
    input  logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] DO,
    output logic              busy,
    input  logic              in_init,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              proto_err
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] do_q, hdo_q, mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic              rd_q, hrd_q, perr_q, xfer, host_act, mem_we;
    logic              unused_ad;
    // AD is a byte address: the word index sits above the two byte-lane bits
    assign unused_ad = ^{AD[31:ADDR_W+2], AD[1:0]};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (REQ) begin
                state_d = (WAIT_STATES == 0) ? ACK : WAIT;
                cnt_d   = CNT_W'(WAIT_STATES - 1);
            end
            WAIT: begin
                state_d = !REQ ? IDLE : (cnt_q == '0) ? ACK : WAIT;
                cnt_d   = (REQ && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // The array is touched only on the edge that enters ACK, so an aborted or reset transfer never writes
    assign xfer      = reset && state_d == ACK;
    assign host_act  = reset && in_init && state_q == IDLE && !REQ;
    assign mem_we    = (xfer && MW && !MR) || (host_act && host_we);
    assign mem_addr  = host_act ? host_addr : AD[ADDR_W+1:2];
    assign mem_din   = host_act ? host_din : DI;
    assign busy      = reset && REQ && state_q != ACK;
    assign DO        = rd_q ? mem_dout : do_q;
    assign host_dout = hrd_q ? mem_dout : hdo_q;
    assign proto_err = perr_q;
    dlx_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram (
        .clk   (clk),
        .we_i  (mem_we),
        .addr_i(mem_addr),
        .din_i (mem_din),
        .dout_o(mem_dout)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            do_q    <= '0;
            hdo_q   <= '0;
            rd_q    <= 1'b0;
            hrd_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= xfer && MR;
            hrd_q   <= host_act;
            if (rd_q) do_q <= mem_dout;
            if (hrd_q) hdo_q <= mem_dout;
            if (REQ && MR && MW) perr_q <= 1'b1;
        end
    end
endmodule
